// File: rtl/moore_ctrl_pkg.sv
// Shared types and default sizes for the Moore sequence-detector stimulus sequencer.
package moore_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ctrl_state_e;

    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/moore_hit_tracker.sv
// Counts sampled detector hits (saturating) and remembers the bit index of the first one.
module moore_hit_tracker
    import moore_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sample_en,
    input  logic             z1,
    input  logic [LEN_W-1:0] idx,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             hit_valid,
    output logic [LEN_W-1:0] first_hit_idx
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [LEN_W-1:0] first_q, first_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            first_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            first_q <= first_d;
        end
    end

    // clr wins over a sample in the same cycle so an abort always leaves clean results.
    always_comb begin
        cnt_d   = cnt_q;
        valid_d = valid_q;
        first_d = first_q;
        if (clr) begin
            cnt_d   = '0;
            valid_d = 1'b0;
            first_d = '0;
        end else if (sample_en && z1) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (!valid_q) begin
                valid_d = 1'b1;
                first_d = idx;
            end
        end
    end

    assign hit_cnt       = cnt_q;
    assign hit_valid     = valid_q;
    assign first_hit_idx = first_q;

endmodule

// File: rtl/moore_seq_ctrl.sv
// Sequencer that resets the detector, shifts a pattern into x1 LSB first and
// reports the number and position of z1 hits through a start/done handshake.
module moore_seq_ctrl
    import moore_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             z1,
    output logic             x1,
    output logic             fsm_rst_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             hit_valid,
    output logic [LEN_W-1:0] first_hit_idx
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    ctrl_state_e      state_q, state_d;
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             x1_q, x1_d;
    logic             fsm_rst_n_q, fsm_rst_n_d;

    logic             start_acc;
    logic             abort_act;
    logic             sample_en;
    logic [LEN_W-1:0] sample_idx;

    assign start_acc = (state_q == IDLE) && start;
    assign abort_act = abort && ((state_q == CLR) || (state_q == RUN) || (state_q == DRAIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            x1_q        <= 1'b0;
            fsm_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            x1_q        <= x1_d;
            fsm_rst_n_q <= fsm_rst_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        len_d   = len_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = pattern;
                    len_d   = (len > PAT_W_L) ? PAT_W_L : len;
                    state_d = CLR;
                end
            end
            CLR: begin
                idx_d   = '0;
                state_d = (len_q == '0) ? DONE : RUN;
            end
            RUN: begin
                shreg_d = shreg_q >> 1;
                if (idx_q == len_q - ONE_L) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + ONE_L;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_act) begin
            state_d = IDLE;
        end
    end

    // x1/fsm_rst_n are registered from the next state so they line up with the state they belong to.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        x1_d        = (state_d == RUN) ? shreg_d[0] : 1'b0;
        fsm_rst_n_d = (state_d != CLR);
        sample_en   = !abort_act && (((state_q == RUN) && (idx_q != '0)) || (state_q == DRAIN));
        sample_idx  = (state_q == DRAIN) ? (len_q - ONE_L) : (idx_q - ONE_L);
    end

    assign x1        = x1_q;
    assign fsm_rst_n = fsm_rst_n_q;

    moore_hit_tracker #(
        .CNT_W (CNT_W),
        .LEN_W (LEN_W)
    ) u_hit_tracker (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (start_acc || abort_act),
        .sample_en     (sample_en),
        .z1            (z1),
        .idx           (sample_idx),
        .hit_cnt       (hit_cnt),
        .hit_valid     (hit_valid),
        .first_hit_idx (first_hit_idx)
    );

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Directed bench for moore_seq_ctrl: run results go through an expected queue checked on done.
module tb_moore_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       z1;
    logic       x1;
    logic       fsm_rst_n;
    logic       busy;
    logic       done;
    logic [3:0] hit_cnt;
    logic       hit_valid;
    logic [3:0] first_hit_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // {done cycle[15:0], hit_cnt[3:0], hit_valid, first_hit_idx[3:0]}
    logic [24:0] exp_q[$];

    moore_seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .pattern       (pattern),
        .len           (len),
        .z1            (z1),
        .x1            (x1),
        .fsm_rst_n     (fsm_rst_n),
        .busy          (busy),
        .done          (done),
        .hit_cnt       (hit_cnt),
        .hit_valid     (hit_valid),
        .first_hit_idx (first_hit_idx)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x1"}, x1, 0);
        check({tag, "_fsm_rst_n"}, fsm_rst_n, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_hit_cnt"}, hit_cnt, 0);
        check({tag, "_hit_valid"}, hit_valid, 0);
        check({tag, "_first_hit_idx"}, first_hit_idx, 0);
    endtask

    // monitor: every done pulse is matched against the oldest pending run
    always @(negedge clk) begin
        logic [24:0] e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc[15:0]), 32'(e[24:9]));
                check("res_hit_cnt", hit_cnt, e[8:5]);
                check("res_hit_valid", hit_valid, e[4]);
                check("res_first_hit_idx", first_hit_idx, e[3:0]);
            end
        end
    end

    // Called just after a rising edge with the DUT idle.
    // mode 0: z1 low, 1: z1 high, 2: z1 high in RUN cycle 2 and DRAIN only.
    task automatic run_case(input logic [7:0] pat, input logic [3:0] ln, input int mode,
                            input bit start_mid, input logic [3:0] e_cnt,
                            input logic e_valid, input logic [3:0] e_idx);
        int le;
        int lat;
        int a;
        le  = (ln > 4'd8) ? 8 : int'(ln);
        lat = (le == 0) ? 2 : le + 3;
        pattern = pat;
        len     = ln;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = cyc;
        exp_q.push_back({16'(a - 1 + lat), e_cnt, e_valid, e_idx});
        for (int i = 1; i <= lat; i++) begin
            case (mode)
                0:       z1 = 1'b0;
                1:       z1 = 1'b1;
                default: z1 = (i == 4) || (i == le + 2);
            endcase
            if (start_mid && i == 3) begin
                start   = 1'b1;
                pattern = 8'hFF;
                len     = 4'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check("run_busy", busy, 1);
            check("run_fsm_rst_n", fsm_rst_n, (i != 1) ? 1 : 0);
            check("run_x1", x1, (i >= 2 && i < 2 + le) ? pat[i-2] : 1'b0);
            @(posedge clk);
            #1;
        end
        z1    = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        check("post_fsm_rst_n", fsm_rst_n, 1);
        check("hold_hit_cnt", hit_cnt, e_cnt);
        check("hold_hit_valid", hit_valid, e_valid);
        check("hold_first_hit_idx", first_hit_idx, e_idx);
        @(posedge clk);
        #1;
    endtask

    // Starts a len-8 run with z1 high and returns at the negedge of RUN cycle 3.
    task automatic start_to_run3();
        pattern = 8'hFF;
        len     = 4'd8;
        z1      = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_hit_cnt", hit_cnt, 2);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        z1      = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("release_fsm_rst_n", fsm_rst_n, 1);
        check("release_busy", busy, 0);
        check("release_x1", x1, 0);
        @(posedge clk);
        #1;

        run_case(8'b1011_0110, 4'd8, 0, 1'b0, 4'd0, 1'b0, 4'd0);
        run_case(8'hA5, 4'd4, 2, 1'b1, 4'd2, 1'b1, 4'd1);
        run_case(8'hFF, 4'd0, 1, 1'b0, 4'd0, 1'b0, 4'd0);
        run_case(8'h3C, 4'd15, 1, 1'b0, 4'd8, 1'b1, 4'd0);

        // abort in RUN cycle 3: back to IDLE with cleared results and no done
        start_to_run3();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        z1    = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_x1", x1, 0);
        check("abort_fsm_rst_n", fsm_rst_n, 1);
        check("abort_hit_cnt", hit_cnt, 0);
        check("abort_hit_valid", hit_valid, 0);
        check("abort_first_hit_idx", first_hit_idx, 0);
        repeat (12) @(posedge clk);
        #1;

        // asynchronous reset in the middle of a run
        start_to_run3();
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        z1 = 1'b0;
        @(negedge clk);
        check_reset_values("midreset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_fsm_rst_n", fsm_rst_n, 1);
        check("midreset_busy", busy, 0);
        @(posedge clk);
        #1;

        run_case(8'h01, 4'd3, 1, 1'b0, 4'd3, 1'b1, 4'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pending_done_count", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
